// File: rtl/fetch_unit.sv
// Instruction-fetch / PC-sequencing stage: IDLE -> FETCH (req/ack) -> EXEC, next PC chosen by pcsel.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky align_fault output and halts on a misaligned JR target.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  pcsel,
   input  logic [31:0] jr_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        align_fault,
`endif
   output logic        instr_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] next_pc;
   logic [31:0] branch_off;

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;

   // JR target is forced word-aligned; with the align check enabled a misaligned target never reaches pc.
   always_comb begin
      branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
      next_pc    = pc_plus4;
      case (pcsel)
         2'b01:   next_pc = pc_plus4 + branch_off;
         2'b10:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
         2'b11:   next_pc = jr_addr & 32'hFFFF_FFFC;
         default: next_pc = pc_plus4;
      endcase
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic jr_misaligned;
   assign jr_misaligned = (pcsel == 2'b11) && (jr_addr[1:0] != 2'b00);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         align_fault <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
               // A latched fault parks the stage here permanently until reset.
               if (!align_fault) begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
               end
`else
               state    <= FETCH;
               imem_req <= 1'b1;
`endif
            end
            FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  state       <= EXEC;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end
            end
            EXEC: begin
               if (enable) begin
                  instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                  if (jr_misaligned) begin
                     align_fault <= 1'b1;
                     state       <= IDLE;
                     imem_req    <= 1'b0;
                  end else begin
`endif
                     pc       <= next_pc;
                     state    <= FETCH;
                     imem_req <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                  end
`endif
               end
            end
            default: begin
               state       <= IDLE;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed PC-sequencing cases plus randomized instructions
// checked against a transaction-level next-PC model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [1:0]  pcsel;
   logic [31:0] jr_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] instr;
   logic        instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        align_fault;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_pc;

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .pcsel      (pcsel),
      .jr_addr    (jr_addr),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .instr      (instr),
`ifdef FETCH_ALIGN_CHECK_EN
      .align_fault(align_fault),
`endif
      .instr_valid(instr_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Architectural next-PC rule written as plain arithmetic on the instruction fields.
   function automatic logic [31:0] refNextPc(input logic [31:0] p, input logic [31:0] ins,
                                             input logic [1:0] sel, input logic [31:0] jr);
      logic [31:0] p4;
      int          off;
      p4 = p + 32'd4;
      case (sel)
         2'd0: return p4;
         2'd1: begin
            off = int'($signed(ins[15:0])) * 4;
            return p4 + 32'(off);
         end
         2'd2: return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
         default: return jr & 32'hFFFF_FFFC;
      endcase
   endfunction

   // One instruction from the FETCH side: wait states, ack, optional freeze, then the enabled EXEC edge.
   task automatic applyStimulus(input int waits, input logic [31:0] data, input int freeze,
                                input logic [1:0] sel, input logic [31:0] jr);
      logic [31:0] exp_next;
      checkOutput("fetch_req", imem_req, 1);
      checkOutput("fetch_addr", imem_addr, model_pc);
      checkOutput("fetch_valid", instr_valid, 0);
      checkOutput("pc_plus4", pc_plus4, model_pc + 32'd4);
      for (int w = 0; w < waits; w++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         enable     = 1'($urandom_range(0, 1));
         @(negedge clk);
         checkOutput("wait_req", imem_req, 1);
         checkOutput("wait_addr", imem_addr, model_pc);
         checkOutput("wait_valid", instr_valid, 0);
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      enable     = 1'($urandom_range(0, 1));
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      checkOutput("exec_valid", instr_valid, 1);
      checkOutput("exec_req", imem_req, 0);
      checkOutput("exec_instr", instr, data);
      checkOutput("exec_pc", pc, model_pc);
      for (int f = 0; f < freeze; f++) begin
         enable     = 1'b0;
         pcsel      = 2'($urandom);
         jr_addr    = $urandom;
         imem_ack   = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         @(negedge clk);
         checkOutput("freeze_valid", instr_valid, 1);
         checkOutput("freeze_req", imem_req, 0);
         checkOutput("freeze_pc", pc, model_pc);
         checkOutput("freeze_instr", instr, data);
      end
      imem_ack = 1'b0;
      enable   = 1'b1;
      pcsel    = sel;
      jr_addr  = jr;
      exp_next = refNextPc(model_pc, data, sel, jr);
      @(negedge clk);
      enable  = 1'b0;
      pcsel   = 2'($urandom);
      jr_addr = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      if (sel == 2'd3 && jr[1:0] != 2'b00) begin
         checkOutput("align_fault", align_fault, 1);
         checkOutput("halt_pc", pc, model_pc);
         for (int h = 0; h < 4; h++) begin
            imem_ack = 1'b1;
            enable   = 1'b1;
            @(negedge clk);
            checkOutput("halt_req", imem_req, 0);
            checkOutput("halt_valid", instr_valid, 0);
            checkOutput("halt_pc", pc, model_pc);
            checkOutput("halt_fault", align_fault, 1);
         end
         imem_ack = 1'b0;
         enable   = 1'b0;
         return;
      end
      checkOutput("no_fault", align_fault, 0);
`endif
      model_pc = exp_next;
      checkOutput("next_req", imem_req, 1);
      checkOutput("next_pc", pc, model_pc);
      checkOutput("next_valid", instr_valid, 0);
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      pcsel      = 2'd0;
      jr_addr    = 32'd0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      model_pc   = RESET_PC;
      repeat (2) @(negedge clk);
      checkOutput("rst_pc", pc, RESET_PC);
      checkOutput("rst_req", imem_req, 0);
      checkOutput("rst_valid", instr_valid, 0);
      checkOutput("rst_instr", instr, 0);
`ifdef FETCH_ALIGN_CHECK_EN
      checkOutput("rst_fault", align_fault, 0);
`endif
      reset = 1'b0;
      #1;
      checkOutput("idle_req", imem_req, 0);
      @(negedge clk);

      applyStimulus(0, 32'h0000_0000, 0, 2'd0, 32'd0);
      applyStimulus(0, 32'h1234_5678, 0, 2'd0, 32'd0);
      checkOutput("seq_pc", pc, 32'h0040_0008);
      applyStimulus(0, 32'h0810_0000, 0, 2'd2, 32'd0);
      checkOutput("jump_back", pc, 32'h0040_0000);
      applyStimulus(3, 32'h1000_0003, 0, 2'd1, 32'd0);
      checkOutput("br_fwd", pc, 32'h0040_0010);
      applyStimulus(0, 32'h1000_FFFE, 0, 2'd1, 32'd0);
      checkOutput("br_back", pc, 32'h0040_000C);
      applyStimulus(0, $urandom, 0, 2'd0, 32'd0);
      applyStimulus(0, 32'h1000_0003, 0, 2'd1, 32'd0);
      checkOutput("br_case2", pc, 32'h0040_0020);
      applyStimulus(0, 32'h0810_0000, 0, 2'd2, 32'd0);
      applyStimulus(0, 32'h0800_0100, 0, 2'd2, 32'd0);
      checkOutput("jal_pc", pc, 32'h0000_0400);
      applyStimulus(0, $urandom, 5, 2'd3, 32'h0040_0040);
      checkOutput("jr_pc", pc, 32'h0040_0040);
      applyStimulus(1, $urandom, 0, 2'd3, 32'hFFFF_FFFC);
      checkOutput("wrap_plus4", pc_plus4, 32'h0000_0000);
      applyStimulus(0, $urandom, 0, 2'd0, 32'd0);
      checkOutput("wrap_pc", pc, 32'h0000_0000);

      for (int i = 0; i < 40; i++) begin
         applyStimulus($urandom_range(0, 3), $urandom, $urandom_range(0, 2),
                       2'($urandom), $urandom & 32'hFFFF_FFFC);
      end

      // Reset while a fetch is waiting; an ack during reset must be ignored.
      imem_ack = 1'b0;
      @(negedge clk);
      checkOutput("pre_rst_req", imem_req, 1);
      reset = 1'b1;
      #1;
      checkOutput("async_pc", pc, RESET_PC);
      checkOutput("async_req", imem_req, 0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      reset    = 1'b0;
      imem_ack = 1'b0;
      #1;
      checkOutput("post_rst_req", imem_req, 0);
      checkOutput("post_rst_instr", instr, 0);
      @(negedge clk);
      model_pc = RESET_PC;
      checkOutput("late_ack_instr", instr, 0);

      applyStimulus(0, $urandom, 0, 2'd3, 32'h0040_0040);
      applyStimulus(0, $urandom, 0, 2'd3, 32'h0040_0042);
`ifndef FETCH_ALIGN_CHECK_EN
      checkOutput("jr_mask_pc", pc, 32'h0040_0040);
      applyStimulus(0, $urandom, 0, 2'd0, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage that sits directly upstream of the instruction decoder/controller.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Presents each fetched instruction to the controller and datapath for one execute window.
- Computes the next PC from the controller's 2-bit pcsel. Encoding: 00 sequential, 01 taken branch, 10 J/JAL, 11 JR.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  processor run enable; low freezes the PC and the execute window
- pcsel  input  2  next-PC select from the controller
- jr_addr  input  32  register value for JR (ReadData1)
- imem_req  output  1  instruction fetch request
- imem_addr  output  32  fetch address; always equal to pc
- imem_ack  input  1  memory has valid data this cycle
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- pc  output  32  current PC
- pc_plus4  output  32  pc+4, for JAL link write and branch base
- instr  output  32  latched instruction
- instr_valid  output  1  execute window active; controller outputs are meaningful

Behaviour:
- Reset (asynchronous, any state, mid-handshake included):
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0.
  - An in-flight ack arriving during reset is ignored.
- States:
  - IDLE: imem_req=0. The next cycle goes unconditionally to FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - On a cycle with imem_ack=1: instr<=imem_rdata and go to EXEC.
    - Otherwise stay in FETCH with the request held.
    - imem_ack is ignored in IDLE and EXEC.
  - EXEC: instr_valid=1, imem_req=0.
    - If enable=1: pc<=next_pc and go to FETCH.
    - If enable=0: stay in EXEC; pc and instr are held; instr_valid stays 1.
- enable does not gate FETCH. A pending fetch completes and the block parks in EXEC.
- Minimum instruction latency is 2 cycles (FETCH with same-cycle ack, then EXEC). Each memory wait cycle adds 1.
- next_pc, computed combinationally in EXEC with 32-bit wrap-around (no overflow detection):
  - 00: pc_plus4
  - 01: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}
  - 11: jr_addr, with alignment handled as below
- pcsel is sampled only on the EXEC edge where enable=1.
- Branch decision (Z) is already folded into pcsel by the controller. This block does not see Z.
- pc_plus4 = pc+4, combinational. pc=32'hFFFF_FFFC gives pc_plus4=0.
- instr_valid and imem_req are never 1 in the same cycle.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output align_fault (1 bit, reset 0).
  - If pcsel=11 and jr_addr[1:0]!=0 on an enabled EXEC edge: pc is not updated, align_fault<=1 (sticky until reset), and the state goes to IDLE and remains there (halted; no further fetches).
- Undefined:
  - No align_fault port.
  - JR target is {jr_addr[31:2],2'b00}, so misaligned low bits are silently masked.

Test Plan:
- Reset then immediate acks:
  - Expect imem_req=0 in the cycle after reset release.
  - Then addresses 0x00400000, 0x00400004, 0x00400008 with pcsel=00, each instruction taking 2 cycles.
- Memory wait states: hold imem_ack=0 for 3 cycles at pc=0x00400000.
  - imem_req and imem_addr stay stable.
  - instr_valid rises in the cycle after the ack, with instr=imem_rdata.
- Branch:
  - Case 1: pc=0x00400010, instr[15:0]=16'hFFFE, pcsel=01 -> next pc=0x0040000C.
  - Case 2: instr[15:0]=16'h0003 -> next pc=0x00400020.
- Jump/JR:
  - pc=0x00400000, instr[25:0]=26'h0000100, pcsel=10 -> pc=0x00000400.
  - pcsel=11, jr_addr=0x00400040 -> pc=0x00400040.
- Freeze and reset mid-operation:
  - enable=0 during EXEC for 5 cycles -> pc, instr, instr_valid=1 all held; resumes on enable=1.
  - Assert reset during a FETCH wait -> pc=RESET_PC immediately; a late ack is ignored.
- FETCH_ALIGN_CHECK_EN:
  - pcsel=11, jr_addr=0x00400042 -> align_fault=1, pc unchanged, imem_req stays 0.
  - Without the macro, the same stimulus gives pc=0x00400040.
